writeback_stage: RTL
====================

# writeback_stage

Final pipeline stage: consumes the registered `pre_wb` result and the stage-3 control, merges load data returned from data memory, and drives the register-file write port. Loads may take a variable number of cycles: the block holds the pipeline with `stall` until `mem_rvalid`. It performs byte/half extraction and sign/zero extension, and flags illegal loads with a sticky `fault`.

## Interface
- `TIMEOUT_CYCLES`, default 255: cycles in LOAD_WAIT before fault. Range 1..65535. Used only with `WB_TIMEOUT_EN`.
- `clk` input 1: single clock, rising edge.
- `rst_n` input 1: reset, asynchronous, active-low.
- `clk_enable` input 1: global pipeline advance. Upstream registers and this stage accept only when it is high.
- `wb_valid` input 1: stage-3 instruction valid.
- `wb_kind` input 2: 00 none, 01 register write from `pre_wb`, 10 load, 11 reserved (treated as none).
- `rd` input 5: destination register.
- `load_funct3` input 3: RV32I load funct3. LB=0, LH=1, LW=2, LBU=4, LHU=5.
- `byte_offset` input 2: address[1:0] of the load.
- `pre_wb` input 32: result from the preceding stage.
- `mem_rdata` input 32: aligned word from data memory.
- `mem_rvalid` input 1: `mem_rdata` valid this cycle.
- `rf_we` output 1: register-file write enable, one-cycle pulse.
- `rf_waddr` output 5: write address.
- `rf_wdata` output 32: write data.
- `stall` output 1: hold request to the global stall controller.
- `fault` output 1: sticky illegal-load or timeout indication.

## Operation
- FSM states: IDLE, LOAD_WAIT, FAULT. All outputs reset to 0 and state resets to IDLE.
- An instruction is accepted at a rising edge with state=IDLE, `clk_enable`=1 and `wb_valid`=1.
- **IDLE, kind 01:**
  - Next cycle: `rf_we`=1, `rf_waddr`=`rd`, `rf_wdata`=`pre_wb`.
  - If `rd`=0, `rf_we` stays 0. Address and data may still update.
- **IDLE, kind 10:**
  - Legality is checked at accept. Illegal funct3 is 3, 6 or 7. Misaligned is LH/LHU with offset[0]=1, or LW with offset≠0.
  - Illegal load: go to FAULT, no write.
  - Legal load: latch `rd`, `load_funct3` and `byte_offset`, then go to LOAD_WAIT.
- **IDLE, kind 00/11 or `wb_valid`=0:** no write.
- **LOAD_WAIT:**
  - Inputs other than `mem_rdata`/`mem_rvalid` are ignored; `clk_enable` is ignored.
  - When `mem_rvalid`=1 at an edge, select byte `mem_rdata[8*off+:8]` or half `mem_rdata[16*off[1]+:16]`.
  - Sign-extend for LB/LH, zero-extend for LBU/LHU, pass the word through for LW.
  - Write to the latched `rd` (suppressed if 0), then return to IDLE.
- **`mem_rvalid` in IDLE or FAULT:** ignored.
- **FAULT:**
  - `fault`=1 and `stall`=1 permanently.
  - `rf_we`=0.
  - Exit only via `rst_n`.
- **`stall`:** equals (state==LOAD_WAIT) or (state==FAULT), decoded combinationally from the registered state.
- **Reset:** asserting `rst_n` mid-load immediately returns to IDLE, clears `stall`, drops the pending write, and clears `rf_we` asynchronously.

## Timing
- Register write: accept at edge N; `rf_we` is high for exactly cycle N..N+1.
- Load:
  - Accept at edge N; `stall` is high from N until the edge where `mem_rvalid` is sampled (edge M).
  - `rf_we` is high in cycle M..M+1 with `stall` already low in that cycle.
  - Minimum load latency is 1 cycle (`mem_rvalid` at edge N+1).
- The next instruction, held upstream during the stall, is accepted at edge M+1. Back-to-back accepts in IDLE are therefore allowed, one per cycle.
- No combinational path from any input to any output. `stall` depends only on state flops.

## Configuration
- `WB_TIMEOUT_EN` defined:
  - A 16-bit counter clears on entry to LOAD_WAIT and increments each LOAD_WAIT cycle without `mem_rvalid`.
  - When the count reaches `TIMEOUT_CYCLES`, the next edge goes to FAULT.
  - `mem_rvalid` on that same edge wins: the write happens and the state returns to IDLE.
- `WB_TIMEOUT_EN` undefined: no counter; LOAD_WAIT waits indefinitely; `TIMEOUT_CYCLES` is unused.

## Test plan
- Kind 01, `rd`=5, `pre_wb`=0xDEADBEEF -> one `rf_we` pulse next cycle, addr 5, data 0xDEADBEEF, `stall` never high.
- Kind 01, `rd`=0, `pre_wb`=0x12345678 -> `rf_we` stays 0.
- LB, off=3, `mem_rvalid` 4 cycles after accept with `mem_rdata`=0x80FF1234 -> `stall` high 4 cycles, then write 0xFFFFFF80.
- LHU, off=2, same data, `rvalid` at N+1 -> write 0x000080FF, `stall` high one cycle; back-to-back kind 01 accepted at the following edge.
- LW, off=1 -> `fault`=1, `stall`=1, no write. Later `mem_rvalid` ignored; `rst_n` low clears everything.
- `WB_TIMEOUT_EN`, `TIMEOUT_CYCLES`=8, no `mem_rvalid` -> FAULT after 8 wait cycles. Also: `rst_n` pulsed mid-LOAD_WAIT -> IDLE, `stall`=0, no write when `rvalid` arrives later.

Source files
------------

// File: rtl/writeback_stage.sv
// Purpose : final pipeline stage; merges load data and drives the register-file write port.
// Latency : 1 cycle for register writes; loads finish 1 cycle after the first mem_rvalid.
// Backpres: raises stall while waiting on a load or when faulted; holds the pipeline.
//
// Ports:
//   clk, rst_n                 clock, async active-low reset
//   clk_enable, wb_valid       accept qualifiers (accept only in IDLE)
//   wb_kind, rd, pre_wb        instruction kind, destination, non-load result
//   load_funct3, byte_offset   load width/sign and address[1:0]
//   mem_rdata, mem_rvalid      aligned load word and its valid strobe
//   rf_we, rf_waddr, rf_wdata  registered register-file write port
//   stall, fault               hold request, sticky illegal-load/timeout flag
//
// Optional feature macro: WB_TIMEOUT_EN (load-wait timeout of TIMEOUT_CYCLES).
module writeback_stage #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clk_enable,
  input  logic        wb_valid,
  input  logic [1:0]  wb_kind,
  input  logic [4:0]  rd,
  input  logic [2:0]  load_funct3,
  input  logic [1:0]  byte_offset,
  input  logic [31:0] pre_wb,
  input  logic [31:0] mem_rdata,
  input  logic        mem_rvalid,
  output logic        rf_we,
  output logic [4:0]  rf_waddr,
  output logic [31:0] rf_wdata,
  output logic        stall,
  output logic        fault
);

  // Elaboration-time range guard on the timeout parameter.
  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
    $error("writeback_stage: TIMEOUT_CYCLES out of range 1..65535");
  end

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    LOAD_WAIT = 2'd1,
    FAULT     = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic        rf_we_q, rf_we_d;
  logic [4:0]  rf_waddr_q, rf_waddr_d;
  logic [31:0] rf_wdata_q, rf_wdata_d;
  logic        fault_q, fault_d;
  logic [4:0]  ld_rd_q, ld_rd_d;
  logic [2:0]  ld_f3_q, ld_f3_d;
  logic [1:0]  ld_off_q, ld_off_d;
`ifdef WB_TIMEOUT_EN
  logic [15:0] cnt_q, cnt_d;
`endif

  logic        load_illegal;
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic [31:0] load_data;

  // Reserved funct3 codes, or halfword/word accesses not naturally aligned.
  always_comb begin
    load_illegal = 1'b0;
    case (load_funct3)
      3'd0, 3'd4: load_illegal = 1'b0;
      3'd1, 3'd5: load_illegal = byte_offset[0];
      3'd2:       load_illegal = (byte_offset != 2'd0);
      default:    load_illegal = 1'b1;
    endcase
  end

  // Extraction uses only the latched load attributes, never live inputs.
  always_comb begin
    byte_sel  = mem_rdata[8*ld_off_q +: 8];
    half_sel  = ld_off_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    load_data = mem_rdata;
    case (ld_f3_q)
      3'd0:    load_data = {{24{byte_sel[7]}}, byte_sel};
      3'd1:    load_data = {{16{half_sel[15]}}, half_sel};
      3'd4:    load_data = {24'd0, byte_sel};
      3'd5:    load_data = {16'd0, half_sel};
      default: load_data = mem_rdata;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    rf_we_d    = 1'b0;
    rf_waddr_d = rf_waddr_q;
    rf_wdata_d = rf_wdata_q;
    fault_d    = fault_q;
    ld_rd_d    = ld_rd_q;
    ld_f3_d    = ld_f3_q;
    ld_off_d   = ld_off_q;
`ifdef WB_TIMEOUT_EN
    cnt_d      = cnt_q;
`endif
    case (state_q)
      IDLE: begin
        if (clk_enable && wb_valid) begin
          case (wb_kind)
            2'b01: begin
              // Address/data follow the instruction even when rd=0; only the enable is gated.
              rf_we_d    = (rd != 5'd0);
              rf_waddr_d = rd;
              rf_wdata_d = pre_wb;
            end
            2'b10: begin
              if (load_illegal) begin
                state_d = FAULT;
                fault_d = 1'b1;
              end else begin
                ld_rd_d  = rd;
                ld_f3_d  = load_funct3;
                ld_off_d = byte_offset;
                state_d  = LOAD_WAIT;
`ifdef WB_TIMEOUT_EN
                cnt_d    = 16'd0;
`endif
              end
            end
            default: ;
          endcase
        end
      end
      LOAD_WAIT: begin
        if (mem_rvalid) begin
          rf_we_d    = (ld_rd_q != 5'd0);
          rf_waddr_d = ld_rd_q;
          rf_wdata_d = load_data;
          state_d    = IDLE;
`ifdef WB_TIMEOUT_EN
        end else if (cnt_q >= 16'(TIMEOUT_CYCLES)) begin
          // Data arriving on the expiry edge still wins (handled above).
          state_d = FAULT;
          fault_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 16'd1;
`endif
        end
      end
      FAULT: begin
        fault_d = 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      rf_we_q    <= 1'b0;
      rf_waddr_q <= 5'd0;
      rf_wdata_q <= 32'd0;
      fault_q    <= 1'b0;
      ld_rd_q    <= 5'd0;
      ld_f3_q    <= 3'd0;
      ld_off_q   <= 2'd0;
`ifdef WB_TIMEOUT_EN
      cnt_q      <= 16'd0;
`endif
    end else begin
      state_q    <= state_d;
      rf_we_q    <= rf_we_d;
      rf_waddr_q <= rf_waddr_d;
      rf_wdata_q <= rf_wdata_d;
      fault_q    <= fault_d;
      ld_rd_q    <= ld_rd_d;
      ld_f3_q    <= ld_f3_d;
      ld_off_q   <= ld_off_d;
`ifdef WB_TIMEOUT_EN
      cnt_q      <= cnt_d;
`endif
    end
  end

  assign rf_we    = rf_we_q;
  assign rf_waddr = rf_waddr_q;
  assign rf_wdata = rf_wdata_q;
  assign fault    = fault_q;
  // Decoded from the state flop only, so there is no input-to-output path.
  assign stall    = (state_q == LOAD_WAIT) || (state_q == FAULT);

endmodule
